// File: rtl/dlatch_if.sv
// Latch data bus: enable and data in, true and complementary outputs back.
interface dlatch_if #(
    parameter int WIDTH = 1
);
    logic             En;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;

    modport master (output En, output D, input Q, input Qbar);
    modport slave  (input En, input D, output Q, output Qbar);
endinterface

// File: rtl/dlatch.sv
// Flop-based emulation of a level-sensitive D latch with complementary outputs.
// Define DLATCH_TRANSPARENT_EN for a zero-cycle combinational bypass while enabled.
module dlatch #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic     clk,
    input  logic     rst,
    dlatch_if.slave  bus
);

    logic             en_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] q;

    // Enable and data travel through matching delay lines so they stay aligned.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0]            vld_pipe;
        logic [SYNC_STAGES-1:0][WIDTH-1:0] d_pipe;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
                d_pipe   <= '0;
            end else begin
                vld_pipe[0] <= bus.En;
                d_pipe[0]   <= bus.D;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    d_pipe[s]   <= d_pipe[s-1];
                end
            end
        end

        assign en_s = vld_pipe[SYNC_STAGES-1];
        assign d_s  = d_pipe[SYNC_STAGES-1];
    end else begin : g_nosync
        assign en_s = bus.En;
        assign d_s  = bus.D;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic q_r;

        always_ff @(posedge clk) begin
            if (rst)       q_r <= 1'b0;
            else if (en_s) q_r <= d_s[i];
        end

`ifdef DLATCH_TRANSPARENT_EN
        // Reset still forces zero so the bypass cannot leak data during reset.
        assign q[i] = rst ? 1'b0 : (en_s ? d_s[i] : q_r);
`else
        assign q[i] = q_r;
`endif
    end

    assign bus.Q    = q;
    assign bus.Qbar = ~q;

endmodule

// File: tb/tb_dlatch.sv
// Randomized and directed bench for dlatch: a narrow unsynchronised instance and a
// wide two-stage instance, both checked against a history-based latch model.
module tb_dlatch;
    localparam int S0 = 0;
    localparam int S1 = 2;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dlatch_if #(.WIDTH(1)) bus0 ();
    dlatch_if #(.WIDTH(4)) bus1 ();

    dlatch #(.WIDTH(1), .SYNC_STAGES(S0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dlatch #(.WIDTH(4), .SYNC_STAGES(S1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    bit       h_rst [MAXC];
    bit       h_en  [MAXC];
    bit       h_d0  [MAXC];
    bit [3:0] h_d4  [MAXC];
    int       n      = 0;
    int       n_chk  = 0;
    int       n_fail = 0;

    // Delayed enable/data seen by the hold register at edge k; a reset inside the
    // delay window leaves zeros in the line.
    function automatic void sync_at(input int k, input int s, input bit wide,
                                    output bit es, output bit [3:0] ds);
        es = 1'b0;
        ds = 4'd0;
        if (k - s < 0) return;
        for (int j = k - s; j < k; j++) if (h_rst[j]) return;
        es = h_en[k-s];
        ds = wide ? h_d4[k-s] : {3'b000, h_d0[k-s]};
    endfunction

    // Held value after edge n: most recent captured data since the last reset.
    function automatic bit [3:0] q_after(input int last, input int s, input bit wide);
        bit       es;
        bit [3:0] ds;
        for (int k = last; k >= 0; k--) begin
            if (h_rst[k]) return 4'd0;
            sync_at(k, s, wide, es, ds);
            if (es) return ds;
        end
        return 4'd0;
    endfunction

    function automatic bit [3:0] q_now(input int s, input bit wide);
        bit [3:0] held;
        bit       es;
        bit [3:0] ds;
        held = (n > 0) ? q_after(n - 1, s, wide) : 4'd0;
`ifdef DLATCH_TRANSPARENT_EN
        if (h_rst[n]) return 4'd0;
        sync_at(n, s, wide, es, ds);
        if (es) return ds;
`else
        es = 1'b0;
        ds = 4'd0;
`endif
        return held;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, n, obs, exp_v);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit d0, input bit [3:0] d4);
        bit [3:0] e0;
        bit [3:0] e1;
        @(negedge clk);
        rst      = r;
        bus0.En  = en;
        bus0.D   = d0;
        bus1.En  = en;
        bus1.D   = d4;
        h_rst[n] = r;
        h_en[n]  = en;
        h_d0[n]  = d0;
        h_d4[n]  = d4;
        #1;
        if (n > 0) begin
            e0 = q_now(S0, 1'b0);
            e1 = q_now(S1, 1'b1);
            check("q0",    {3'b000, bus0.Q},    e0);
            check("qbar0", {3'b000, bus0.Qbar}, {3'b000, ~e0[0]});
            check("q1",    bus1.Q,              e1);
            check("qbar1", bus1.Qbar,           ~e1);
        end
        n++;
    endtask

    initial begin
        rst     = 1'b1;
        bus0.En = 1'b0;
        bus0.D  = '0;
        bus1.En = 1'b0;
        bus1.D  = '0;

        // Reset, then hold with D low
        step(1, 0, 0, 4'h0);
        step(0, 0, 0, 4'h0);
        check("reset_q0", {3'b000, bus0.Q}, 4'h0);
        check("reset_qbar0", {3'b000, bus0.Qbar}, 4'h1);
        // Hold while D toggles
        for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hF);
        // Transparent: D low, then high
        step(0, 1, 0, 4'h0);
        step(0, 1, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 4'hA);
        // Hold after D high, then D drops
        step(0, 0, 1, 4'h5);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 4'h3);
        // Reset mid-transparency
        for (int i = 0; i < 4; i++) step(0, 1, 1, 4'hC);
        step(1, 1, 1, 4'hC);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h9);
        // Single-cycle enable pulse and simultaneous En/D change
        step(0, 1, 1, 4'h6);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h1);
        step(0, 1, 0, 4'h0);
        step(0, 0, 1, 4'hF);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'hE);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
